// File: rtl/tlu_trigger_fanout.sv
// tlu_trigger_fanout: fans a trigger request out to up to 16 DUT channels.
// A request is accepted only from IDLE, with a non-empty channel mask and no
// enabled DUT reporting busy. An accepted trigger is counted and pulsed to
// the snapshotted channel mask for PULSE_LEN cycles. If any snapshotted
// channel runs in handshake mode, the block then waits until each of those
// DUTs has raised and dropped its busy line.
//
// Optional feature: define TLU_FANOUT_TIMEOUT_EN to bound the handshake wait
// to TIMEOUT cycles. Each channel still pending when the limit is reached
// sets a sticky TIMEOUT_ERR bit. Without the macro the wait is unbounded,
// TIMEOUT_ERR is tied to zero and ERR_CLR is ignored.
//
// Handshake semantics: DUT_BUSY is a level, already synchronous to BUS_CLK.
// A handshake channel counts as done once busy has been sampled high and
// then sampled low on a later cycle. Busy seen during the FIRE pulse counts.
module tlu_trigger_fanout #(
    parameter int N_DUT     = 6,
    parameter int ID_WIDTH  = 16,
    parameter int PULSE_LEN = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    input  logic                TRIG_IN,
    input  logic [N_DUT-1:0]    EN_MASK,
    input  logic [N_DUT-1:0]    HANDSHAKE_MODE,
    input  logic [N_DUT-1:0]    DUT_BUSY,
    output logic [N_DUT-1:0]    DUT_TRIGGER,
    output logic [ID_WIDTH-1:0] TRIG_ID,
    output logic                ACCEPTED,
    output logic                SKIPPED,
    output logic                BUSY,
    output logic [N_DUT-1:0]    TIMEOUT_ERR,
    input  logic                ERR_CLR,
    output logic [1:0]          state_dbg
);

    // Pulse counter reloads with PULSE_LEN-1 and the pulse ends when it reads zero.
    localparam int PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PCNT_W-1:0] PULSE_RELOAD = PCNT_W'(PULSE_LEN - 1);
    // Last WAIT cycle index before the handshake gives up.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PCNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [N_DUT-1:0]    trig_q, trig_d;
    logic [N_DUT-1:0]    hs_snap_q, hs_snap_d;
    logic [N_DUT-1:0]    seen_q, seen_d;
    logic [N_DUT-1:0]    done_q, done_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic                acc_q, acc_d;
    logic                skip_q, skip_d;

    logic                accept;
    logic [N_DUT-1:0]    seen_upd;
    logic [N_DUT-1:0]    done_upd;
    logic                all_done;

`ifdef TLU_FANOUT_TIMEOUT_EN
    logic [15:0]         wait_cnt_q, wait_cnt_d;
    logic [N_DUT-1:0]    err_q, err_d;
    logic [N_DUT-1:0]    err_set;
`else
    logic                unused_cfg;
    assign unused_cfg = ERR_CLR ^ (^TIMEOUT_LAST);
`endif

    // Accept test and handshake bookkeeping shared by FIRE and WAIT.
    always_comb begin
        accept   = (state_q == ST_IDLE) && TRIG_IN && (|EN_MASK) && !(|(EN_MASK & DUT_BUSY));
        seen_upd = seen_q | (hs_snap_q & DUT_BUSY);
        done_upd = done_q | (seen_q & ~DUT_BUSY);
        all_done = ((done_upd & hs_snap_q) == hs_snap_q);
    end

    // Next-state logic for the trigger FSM and all of its registered outputs.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        trig_d      = trig_q;
        hs_snap_d   = hs_snap_q;
        seen_d      = seen_q;
        done_d      = done_q;
        id_d        = id_q;
        acc_d       = 1'b0;
        skip_d      = 1'b0;
`ifdef TLU_FANOUT_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        err_set     = '0;
`endif

        // TRIG_IN is a level: every sampled high that is not accepted is a skip.
        if (TRIG_IN && !accept) begin
            skip_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_FIRE;
                    id_d        = id_q + ID_WIDTH'(1);
                    acc_d       = 1'b1;
                    trig_d      = EN_MASK;
                    hs_snap_d   = EN_MASK & HANDSHAKE_MODE;
                    seen_d      = '0;
                    done_d      = '0;
                    pulse_cnt_d = PULSE_RELOAD;
                end
            end
            ST_FIRE: begin
                seen_d = seen_upd;
                done_d = done_upd;
                if (pulse_cnt_q == '0) begin
                    trig_d = '0;
                    if (|hs_snap_q) begin
                        state_d = ST_WAIT;
`ifdef TLU_FANOUT_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    pulse_cnt_d = pulse_cnt_q - PCNT_W'(1);
                end
            end
            ST_WAIT: begin
                seen_d = seen_upd;
                done_d = done_upd;
                if (all_done) begin
                    state_d = ST_IDLE;
                end
`ifdef TLU_FANOUT_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    err_set = hs_snap_q & ~done_upd;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                trig_d  = '0;
            end
        endcase

`ifdef TLU_FANOUT_TIMEOUT_EN
        // A new timeout beats a simultaneous clear for the same channel.
        err_d = (ERR_CLR ? '0 : err_q) | err_set;
`endif
    end

    // State registers; reset is asynchronous so outputs drop immediately.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q     <= ST_IDLE;
            pulse_cnt_q <= '0;
            trig_q      <= '0;
            hs_snap_q   <= '0;
            seen_q      <= '0;
            done_q      <= '0;
            id_q        <= '0;
            acc_q       <= 1'b0;
            skip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            trig_q      <= trig_d;
            hs_snap_q   <= hs_snap_d;
            seen_q      <= seen_d;
            done_q      <= done_d;
            id_q        <= id_d;
            acc_q       <= acc_d;
            skip_q      <= skip_d;
        end
    end

`ifdef TLU_FANOUT_TIMEOUT_EN
    // Timeout counter and sticky error flags.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            wait_cnt_q <= '0;
            err_q      <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign TIMEOUT_ERR = err_q;
`else
    assign TIMEOUT_ERR = '0;
`endif

    assign DUT_TRIGGER = trig_q;
    assign TRIG_ID     = id_q;
    assign ACCEPTED    = acc_q;
    assign SKIPPED     = skip_q;
    assign BUSY        = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule
